// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Host-side push handshake for the UART transmitter FIFO.
//   sdata    : byte to enqueue (master -> slave)
//   tx_start : push request, sdata valid this cycle (master -> slave)
//   tx_ready : FIFO can accept a byte (slave -> master)
// A push happens on a clock edge where tx_start && tx_ready.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic [7:0] sdata;
  logic       tx_start;
  logic       tx_ready;

  modport master (
    output sdata,
    output tx_start,
    input  tx_ready
  );

  modport slave (
    input  sdata,
    input  tx_start,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a power-of-two byte FIFO. Bytes pushed by the host are
// queued and serialised as 8N1 frames (LSB first) on txd. Frames go out
// back-to-back with no idle gap while the FIFO holds data.
//
// Ports:
//   clk        : clock
//   rstn       : synchronous active-low reset (aborts any frame, empties FIFO)
//   host       : uart_tx_fifo_if.slave (sdata, tx_start, tx_ready)
//   txd        : registered serial output, idle high
//   busy       : high while a frame is in progress or the FIFO is non-empty
//   fifo_count : FIFO occupancy, 0..2**FIFO_AW
//
// Parameters:
//   CLK_PER_HALF_BIT : clocks per half bit (bit period = 2*CLK_PER_HALF_BIT)
//   FIFO_AW          : FIFO address width, depth = 2**FIFO_AW
//   PARITY_ODD       : parity sense when parity is compiled in (0 even, 1 odd)
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// data bit 7 and the stop bit (11-bit frame). Without it the frame is 8N1.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_AW          = 4,
  parameter int PARITY_ODD       = 0
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_fifo_if.slave      host,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int DEPTH    = 2 ** FIFO_AW;
  localparam int CNT_W    = $clog2(BIT_CLKS);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   COUNT_ZERO = {(FIFO_AW + 1){1'b0}};
  localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  // Parity of a byte with the configured sense folded in.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`else
  // PARITY_ODD only matters when parity is compiled in.
  logic               unused_parity_odd_s;
  assign unused_parity_odd_s = PARITY_ODD[0];
`endif

  logic               push_s;
  logic               pop_s;
  logic               bit_done_s;
  logic               tx_ready_s;
  logic               fifo_nonempty_s;
  logic [7:0]         head_s;

  // ---------------------------------------------------------------------------
  // FIFO handshake
  // ---------------------------------------------------------------------------
  assign tx_ready_s      = (count_q != COUNT_FULL);
  assign fifo_nonempty_s = (count_q != COUNT_ZERO);
  assign push_s          = host.tx_start && tx_ready_s;
  assign head_s          = mem_q[rptr_q];
  assign bit_done_s      = (cnt_q == CNT_LAST);

  assign host.tx_ready = tx_ready_s;
  assign txd           = txd_q;
  assign busy          = busy_q;
  assign fifo_count    = count_q;

  // FSM next state, bit timing, pop request and next line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // The bit counter free-runs 0..BIT_CLKS-1 whenever a frame is active.
    if (state_q == ST_IDLE) begin
      cnt_d = CNT_ZERO;
    end else if (bit_done_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty_s) begin
          pop_s   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          // Chain straight into the next start bit when more data waits.
          if (fifo_nonempty_s) begin
            pop_s   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load the shift register (and parity) from the FIFO head on a pop.
    if (pop_s) begin
      shift_d = head_s;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_bit(head_s, PARITY_ODD[0]);
`endif
    end else begin
      shift_d = shift_d;
    end
  end

  // Line level for the current state; registered so txd lags state by one clock.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // busy is registered from next-state values so it drops on the IDLE entry edge.
  always_comb begin
    busy_d = (state_d != ST_IDLE) || (count_d != COUNT_ZERO);
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      wptr_q  <= {FIFO_AW{1'b0}};
      rptr_q  <= {FIFO_AW{1'b0}};
      count_q <= COUNT_ZERO;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= host.sdata;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed self-checking bench for uart_tx_fifo with CLK_PER_HALF_BIT=4
// (8 clocks per bit) and FIFO_AW=2 (depth 4). Inputs change and outputs are
// sampled on the falling edge; "j" in the tests counts rising edges after the
// first push edge N (j=0 is the sample just after edge N).
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPH   = 4;
  localparam int BITC  = 8;
  localparam int AW    = 2;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FC    = FBITS * BITC;

  logic          clk;
  logic          rstn;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;
  int            n_tests;
  int            n_fail;
  int            max_cnt;

  uart_tx_fifo_if host();

  uart_tx_fifo #(
    .CLK_PER_HALF_BIT (CPH),
    .FIFO_AW          (AW),
    .PARITY_ODD       (PODD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .host       (host),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track peak FIFO occupancy.
  always @(negedge clk) begin
    if (rstn === 1'b1 && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  // Expected line level for bit position p of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return (^b) ^ 1'(PODD);
`endif
    return 1'b1;
  endfunction

  // Receiver: wait for a start bit, sample each bit mid-period, end at the
  // sample where the next frame's start bit would begin.
  task automatic rx_frame(output logic [7:0] b, output logic stopb, output logic ok);
    ok = 1'b0;
    b = 8'h00;
    stopb = 1'b0;
    for (int w = 0; w < 300; w++) begin
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (BITC / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      b[i] = txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BITC) @(negedge clk);
`endif
    repeat (BITC) @(negedge clk);
    stopb = txd;
    repeat (BITC / 2) @(negedge clk);
  endtask

  task automatic test_reset();
    host.tx_start = 1'b0;
    host.sdata    = 8'h00;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_tests++;
      if (txd !== 1'b1 || busy !== 1'b0 || host.tx_ready !== 1'b1 || fifo_count !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got txd=%b busy=%b rdy=%b cnt=%0d want 1 0 1 0",
                 c, txd, busy, host.tx_ready, fifo_count);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] rx;
    logic       e;
    int         k;
    rx = 8'h00;
    host.sdata = 8'hA5;
    host.tx_start = 1'b1;
    @(negedge clk);
    host.tx_start = 1'b0;
    n_tests++;
    if (fifo_count !== 3'd1 || busy !== 1'b1 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push got cnt=%0d busy=%b txd=%b want 1 1 1", fifo_count, busy, txd);
    end
    for (int j = 1; j <= FC + 1; j++) begin
      @(negedge clk);
      k = j - 2;
      e = (j >= 2 && k < FC) ? exp_bit(8'hA5, k / BITC) : 1'b1;
      n_tests++;
      if (txd !== e) begin
        n_fail++;
        $display("FAIL single_txd j=%0d got %b want %b", j, txd, e);
      end
      n_tests++;
      if (busy !== (j <= FC)) begin
        n_fail++;
        $display("FAIL single_busy j=%0d got %b want %b", j, busy, (j <= FC));
      end
      if (k >= 0 && (k % BITC) == BITC / 2 && k / BITC >= 1 && k / BITC <= 8) rx[k / BITC - 1] = txd;
    end
    n_tests++;
    if (rx !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_decode got %h want a5", rx);
    end
    n_tests++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_empty got cnt=%0d want 0", fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [5];
    logic       e;
    int         k;
    data[0] = 8'h01; data[1] = 8'h02; data[2] = 8'h03; data[3] = 8'h04; data[4] = 8'h05;
    max_cnt = 0;
    for (int j = 0; j <= 5 * FC + 100; j++) begin
      host.tx_start = (j <= 5);
      host.sdata    = (j < 5) ? data[j] : 8'hFF;
      @(negedge clk);
      host.tx_start = 1'b0;
      if (j == 4) begin
        n_tests++;
        if (host.tx_ready !== 1'b0 || fifo_count !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_full got rdy=%b cnt=%0d want 0 4", host.tx_ready, fifo_count);
        end
      end
      if (j == 5) begin
        n_tests++;
        if (fifo_count !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_push_full_ignored got cnt=%0d want 4", fifo_count);
        end
      end
      k = j - 2;
      e = (j >= 2 && k < 5 * FC) ? exp_bit(data[k / FC], (k % FC) / BITC) : 1'b1;
      n_tests++;
      if (txd !== e) begin
        n_fail++;
        $display("FAIL b2b_txd j=%0d got %b want %b", j, txd, e);
      end
      if (j >= 5 * FC) begin
        n_tests++;
        if (busy !== (j <= 5 * FC)) begin
          n_fail++;
          $display("FAIL b2b_busy j=%0d got %b want %b", j, busy, (j <= 5 * FC));
        end
      end
    end
    n_tests++;
    if (max_cnt > 4 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_count got max=%0d cnt=%0d want <=4 0", max_cnt, fifo_count);
    end
  endtask

  task automatic test_wrap();
    int         sizes [4];
    logic [7:0] b;
    logic       sb;
    logic       ok;
    int         sent;
    int         rcvd;
    sizes[0] = 3; sizes[1] = 3; sizes[2] = 3; sizes[3] = 1;
    sent = 0;
    rcvd = 0;
    max_cnt = 0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < sizes[g]; i++) begin
        host.sdata    = 8'h30 + 8'(sent);
        host.tx_start = 1'b1;
        @(negedge clk);
        host.tx_start = 1'b0;
        sent++;
      end
      for (int i = 0; i < sizes[g]; i++) begin
        rx_frame(b, sb, ok);
        n_tests++;
        if (!ok || b !== 8'h30 + 8'(rcvd) || sb !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_order idx=%0d got ok=%b byte=%h stop=%b want 1 %h 1",
                   rcvd, ok, b, sb, 8'h30 + 8'(rcvd));
        end
        rcvd++;
      end
    end
    n_tests++;
    if (max_cnt > 4 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end got max=%0d cnt=%0d busy=%b want <=4 0 0", max_cnt, fifo_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] data [3];
    data[0] = 8'h3C; data[1] = 8'h11; data[2] = 8'h22;
    for (int j = 0; j < 3; j++) begin
      host.sdata    = data[j];
      host.tx_start = 1'b1;
      @(negedge clk);
      host.tx_start = 1'b0;
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (txd !== 1'b0 || fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre got txd=%b cnt=%0d want 0 2", txd, fifo_count);
    end
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (txd !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || host.tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_abort got txd=%b cnt=%0d busy=%b rdy=%b want 1 0 0 1",
               txd, fifo_count, busy, host.tx_ready);
    end
    rstn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_tests++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet cyc=%0d got txd=%b busy=%b want 1 0", c, txd, busy);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic e;
    int   k;
    host.sdata    = 8'h07;
    host.tx_start = 1'b1;
    @(negedge clk);
    host.tx_start = 1'b0;
    for (int j = 1; j <= FC + 1; j++) begin
      @(negedge clk);
      k = j - 2;
      e = (j >= 2 && k < FC) ? exp_bit(8'h07, k / BITC) : 1'b1;
      n_tests++;
      if (txd !== e) begin
        n_fail++;
        $display("FAIL parity_txd j=%0d got %b want %b", j, txd, e);
      end
      // 0x07 has three ones: even-sense parity bit is 1.
      if (k == 9 * BITC + BITC / 2) begin
        n_tests++;
        if (txd !== (PODD == 0 ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL parity_bit got %b want %b", txd, (PODD == 0 ? 1'b1 : 1'b0));
        end
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_len got busy=%b want 0 after %0d cycles", busy, FC);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    max_cnt = 0;
    rstn    = 1'b0;
    host.tx_start = 1'b0;
    host.sdata    = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
